// File: rtl/bp_be_pkg.sv
// Backend shared types: late-writeback request packet declared through a width macro.
// Optional bypass feature in the arbiter is enabled by BP_BE_LATE_WB_BYPASS_EN.
`define BP_BE_DECLARE_LATE_WB_REQ_S(dw, ra, fw) \
  typedef struct packed { \
    logic [ra-1:0] rd_addr; \
    logic          ird_w_v; \
    logic          frd_w_v; \
    logic [dw-1:0] data; \
    logic [fw-1:0] fflags; \
  } bp_be_late_wb_req_s

`define BP_BE_DECLARE_WB_PKT_S(dw, ra) \
  typedef struct packed { \
    logic          ird_w_v; \
    logic          frd_w_v; \
    logic [ra-1:0] rd_addr; \
    logic [dw-1:0] data; \
  } bp_be_wb_pkt_s

package bp_be_pkg;

  function automatic int bp_be_cnt_width(input int max_cnt);
    return $clog2(max_cnt + 1);
  endfunction

  function automatic int bp_be_idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bp_be_late_wb_rr_pick.sv
// Combinational round-robin picker: first set request after last_i, with wrap.
module bp_be_late_wb_rr_pick
  import bp_be_pkg::*;
#(
  parameter int num_req_p = 3,
  parameter int lg_p      = bp_be_idx_width(num_req_p)
) (
  input  logic [num_req_p-1:0] req_i,
  input  logic [lg_p-1:0]      last_i,
  output logic [num_req_p-1:0] grant_oh_o,
  output logic [lg_p-1:0]      grant_idx_o,
  output logic                 any_v_o
);

  int   idx;
  logic found;

  always_comb begin
    grant_oh_o  = '0;
    grant_idx_o = '0;
    found       = 1'b0;
    idx         = 0;
    for (int k = 1; k <= num_req_p; k++) begin
      idx = (int'(last_i) + k) % num_req_p;
      if (!found && req_i[idx]) begin
        found            = 1'b1;
        grant_oh_o[idx]  = 1'b1;
        grant_idx_o      = lg_p'(idx);
      end
    end
  end

  assign any_v_o = |req_i;

endmodule

// File: rtl/bp_be_late_wb_arbiter.sv
// Late-writeback arbiter: round-robin pick among long-latency producers plus in-flight counter.
// Define BP_BE_LATE_WB_BYPASS_EN for a zero-latency path when the output register is empty.
module bp_be_late_wb_arbiter
  import bp_be_pkg::*;
#(
  parameter int num_req_p         = 3,
  parameter int data_width_p      = 64,
  parameter int reg_addr_width_p  = 5,
  parameter int fflags_width_p    = 5,
  parameter int max_outstanding_p = 16,
  localparam int lg_lp  = bp_be_idx_width(num_req_p),
  localparam int cnt_lp = bp_be_cnt_width(max_outstanding_p)
) (
  input  logic                                  clk_i,
  input  logic                                  reset_i,
  input  logic [num_req_p-1:0]                  req_v_i,
  input  logic [num_req_p*reg_addr_width_p-1:0] req_rd_addr_i,
  input  logic [num_req_p-1:0]                  req_ird_w_v_i,
  input  logic [num_req_p-1:0]                  req_frd_w_v_i,
  input  logic [num_req_p*data_width_p-1:0]     req_data_i,
  input  logic [num_req_p*fflags_width_p-1:0]   req_fflags_i,
  output logic [num_req_p-1:0]                  req_yumi_o,
  output logic                                  wb_v_o,
  output logic [reg_addr_width_p-1:0]           wb_rd_addr_o,
  output logic                                  wb_ird_w_v_o,
  output logic                                  wb_frd_w_v_o,
  output logic [data_width_p-1:0]               wb_data_o,
  output logic [fflags_width_p-1:0]             wb_fflags_o,
  input  logic                                  wb_yumi_i,
  input  logic                                  score_v_i,
  output logic [cnt_lp-1:0]                     pending_count_o,
  output logic                                  empty_o,
  output logic                                  full_o
);

  `BP_BE_DECLARE_LATE_WB_REQ_S(data_width_p, reg_addr_width_p, fflags_width_p);

  bp_be_late_wb_req_s req_pkt [num_req_p];
  bp_be_late_wb_req_s win_pkt, out_pkt, pkt_q, pkt_d;

  logic                 wb_v_q, wb_v_d;
  logic [lg_lp-1:0]     last_q, last_d, grant_idx;
  logic [num_req_p-1:0] grant_oh;
  logic                 any_v, load, load_reg, dec;
  logic [cnt_lp-1:0]    cnt_q, cnt_d;

  for (genvar i = 0; i < num_req_p; i++) begin : g_unpack
    assign req_pkt[i].rd_addr = req_rd_addr_i[i*reg_addr_width_p +: reg_addr_width_p];
    assign req_pkt[i].ird_w_v = req_ird_w_v_i[i];
    assign req_pkt[i].frd_w_v = req_frd_w_v_i[i];
    assign req_pkt[i].data    = req_data_i[i*data_width_p +: data_width_p];
    assign req_pkt[i].fflags  = req_fflags_i[i*fflags_width_p +: fflags_width_p];
  end

  bp_be_late_wb_rr_pick #(
    .num_req_p(num_req_p),
    .lg_p     (lg_lp)
  ) u_pick (
    .req_i      (req_v_i),
    .last_i     (last_q),
    .grant_oh_o (grant_oh),
    .grant_idx_o(grant_idx),
    .any_v_o    (any_v)
  );

  assign win_pkt = req_pkt[grant_idx];
  assign load    = (~wb_v_q | wb_yumi_i) & any_v;

`ifdef BP_BE_LATE_WB_BYPASS_EN
  logic byp;
  // A bypassed winner consumed in the same cycle never touches the register
  assign byp      = ~wb_v_q & any_v;
  assign load_reg = load & ~(byp & wb_yumi_i);
  assign wb_v_o   = wb_v_q | byp;
  assign out_pkt  = byp ? win_pkt : pkt_q;
`else
  assign load_reg = load;
  assign wb_v_o   = wb_v_q;
  assign out_pkt  = pkt_q;
`endif

  assign req_yumi_o = load ? grant_oh : '0;
  assign last_d     = load ? grant_idx : last_q;
  assign pkt_d      = load_reg ? win_pkt : pkt_q;
  assign wb_v_d     = load_reg | (wb_v_q & ~wb_yumi_i);

  assign wb_rd_addr_o = out_pkt.rd_addr;
  assign wb_ird_w_v_o = out_pkt.ird_w_v;
  assign wb_frd_w_v_o = out_pkt.frd_w_v;
  assign wb_data_o    = out_pkt.data;
  assign wb_fflags_o  = out_pkt.fflags;

  assign dec = wb_v_o & wb_yumi_i;

  always_comb begin
    cnt_d = cnt_q;
    case ({score_v_i, dec})
      2'b10:   if (!full_o)  cnt_d = cnt_q + cnt_lp'(1);
      2'b01:   if (!empty_o) cnt_d = cnt_q - cnt_lp'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  assign pending_count_o = cnt_q;
  assign empty_o         = (cnt_q == '0);
  assign full_o          = (cnt_q == cnt_lp'(max_outstanding_p));

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wb_v_q <= 1'b0;
      pkt_q  <= '0;
      last_q <= lg_lp'(num_req_p - 1);
      cnt_q  <= '0;
    end else begin
      wb_v_q <= wb_v_d;
      pkt_q  <= pkt_d;
      last_q <= last_d;
      cnt_q  <= cnt_d;
    end
  end

  a_score_full: assert property (@(posedge clk_i) disable iff (reset_i)
    !(score_v_i & full_o & ~dec));
  a_dec_empty: assert property (@(posedge clk_i) disable iff (reset_i)
    !(dec & empty_o & ~score_v_i));
  a_rf_both: assert property (@(posedge clk_i) disable iff (reset_i)
    ~|(req_v_i & req_ird_w_v_i & req_frd_w_v_i));
  a_yumi_no_v: assert property (@(posedge clk_i) disable iff (reset_i)
    !(wb_yumi_i & ~wb_v_o));

endmodule

// File: tb/tb_bp_be_late_wb_arbiter.sv
// Directed bench for bp_be_late_wb_arbiter with default parameters.
module tb_bp_be_late_wb_arbiter;

  logic          clk_i = 1'b0;
  logic          reset_i;
  logic [2:0]    req_v_i;
  logic [14:0]   req_rd_addr_i;
  logic [2:0]    req_ird_w_v_i;
  logic [2:0]    req_frd_w_v_i;
  logic [191:0]  req_data_i;
  logic [14:0]   req_fflags_i;
  logic [2:0]    req_yumi_o;
  logic          wb_v_o;
  logic [4:0]    wb_rd_addr_o;
  logic          wb_ird_w_v_o;
  logic          wb_frd_w_v_o;
  logic [63:0]   wb_data_o;
  logic [4:0]    wb_fflags_o;
  logic          wb_yumi_i;
  logic          score_v_i;
  logic [4:0]    pending_count_o;
  logic          empty_o;
  logic          full_o;

  int errors = 0;
  int checks = 0;

  bp_be_late_wb_arbiter dut (
    .clk_i          (clk_i),
    .reset_i        (reset_i),
    .req_v_i        (req_v_i),
    .req_rd_addr_i  (req_rd_addr_i),
    .req_ird_w_v_i  (req_ird_w_v_i),
    .req_frd_w_v_i  (req_frd_w_v_i),
    .req_data_i     (req_data_i),
    .req_fflags_i   (req_fflags_i),
    .req_yumi_o     (req_yumi_o),
    .wb_v_o         (wb_v_o),
    .wb_rd_addr_o   (wb_rd_addr_o),
    .wb_ird_w_v_o   (wb_ird_w_v_o),
    .wb_frd_w_v_o   (wb_frd_w_v_o),
    .wb_data_o      (wb_data_o),
    .wb_fflags_o    (wb_fflags_o),
    .wb_yumi_i      (wb_yumi_i),
    .score_v_i      (score_v_i),
    .pending_count_o(pending_count_o),
    .empty_o        (empty_o),
    .full_o         (full_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #2;
  endtask

  int         g_seq [6] = '{2, 0, 1, 2, 0, 1};
  logic [4:0] rd_of [3] = '{5'd3, 5'd7, 5'd12};

  initial begin
    reset_i       = 1'b1;
    req_v_i       = '0;
    wb_yumi_i     = 1'b0;
    score_v_i     = 1'b0;
    req_rd_addr_i = {5'd12, 5'd7, 5'd3};
    req_ird_w_v_i = 3'b110;
    req_frd_w_v_i = 3'b001;
    req_data_i    = {64'hC2, 64'hDEAD, 64'hA0};
    req_fflags_i  = {5'd0, 5'd0, 5'd1};
    cyc();
    cyc();
    reset_i = 1'b0;
    #1;
    chk("rst_wb_v", wb_v_o, 0);
    chk("rst_yumi", req_yumi_o, 0);
    chk("rst_cnt", pending_count_o, 0);
    chk("rst_empty", empty_o, 1);
    chk("rst_full", full_o, 0);

`ifndef BP_BE_LATE_WB_BYPASS_EN
    // single requester, one cycle latency
    req_v_i   = 3'b010;
    score_v_i = 1'b1;
    #1;
    chk("single_yumi", req_yumi_o, 3'b010);
    cyc();
    req_v_i   = '0;
    score_v_i = 1'b0;
    #1;
    chk("single_wb_v", wb_v_o, 1);
    chk("single_rd", wb_rd_addr_o, 7);
    chk("single_data", wb_data_o, 64'hDEAD);
    chk("single_ird", wb_ird_w_v_o, 1);
    chk("single_frd", wb_frd_w_v_o, 0);
    chk("single_cnt", pending_count_o, 1);
    wb_yumi_i = 1'b1;
    cyc();
    wb_yumi_i = 1'b0;
    #1;
    chk("clear_wb_v", wb_v_o, 0);
    chk("clear_cnt", pending_count_o, 0);

    // round robin, last grant was 1
    req_v_i   = 3'b111;
    score_v_i = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) wb_yumi_i = 1'b1;
      #1;
      chk("rr_yumi", req_yumi_o, 64'(1) << g_seq[k]);
      if (k > 0) chk("rr_rd", wb_rd_addr_o, rd_of[g_seq[k-1]]);
      cyc();
    end

    // backpressure holds packet from requester 1
    wb_yumi_i = 1'b0;
    score_v_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("bp_yumi", req_yumi_o, 0);
      chk("bp_wb_v", wb_v_o, 1);
      chk("bp_rd", wb_rd_addr_o, 7);
      chk("bp_data", wb_data_o, 64'hDEAD);
      cyc();
    end
    wb_yumi_i = 1'b1;
    score_v_i = 1'b1;
    #1;
    chk("bp_resume", req_yumi_o, 3'b100);
    cyc();
    req_v_i   = '0;
    score_v_i = 1'b0;
    #1;
    chk("bp_last_rd", wb_rd_addr_o, 12);
    chk("bp_last_ff", wb_fflags_o, 0);
    cyc();
    wb_yumi_i = 1'b0;
    #1;
    chk("rr_done_v", wb_v_o, 0);
    chk("rr_done_cnt", pending_count_o, 0);
`else
    // bypass: zero latency when register empty
    req_v_i   = 3'b001;
    score_v_i = 1'b1;
    wb_yumi_i = 1'b1;
    #1;
    chk("byp_wb_v", wb_v_o, 1);
    chk("byp_yumi", req_yumi_o, 3'b001);
    chk("byp_rd", wb_rd_addr_o, 3);
    chk("byp_ff", wb_fflags_o, 1);
    cyc();
    req_v_i   = '0;
    score_v_i = 1'b0;
    wb_yumi_i = 1'b0;
    #1;
    chk("byp_after_v", wb_v_o, 0);
    chk("byp_after_cnt", pending_count_o, 0);
    req_v_i = 3'b011;
    #1;
    chk("byp_hold_v", wb_v_o, 1);
    chk("byp_hold_yumi", req_yumi_o, 3'b010);
    cyc();
    req_v_i = '0;
    #1;
    chk("byp_reg_v", wb_v_o, 1);
    chk("byp_reg_rd", wb_rd_addr_o, 7);
    score_v_i = 1'b1;
    wb_yumi_i = 1'b1;
    cyc();
    score_v_i = 1'b0;
    wb_yumi_i = 1'b0;
    #1;
    chk("byp_drain_v", wb_v_o, 0);
`endif

    // counter fill, saturate, drain
    for (int k = 0; k < 16; k++) begin
      score_v_i = 1'b1;
      req_v_i   = (k == 15) ? 3'b001 : 3'b000;
      #1;
      if (k == 15) chk("cnt_pre_full", full_o, 0);
      cyc();
    end
    score_v_i = 1'b0;
    req_v_i   = '0;
    #1;
    chk("cnt_16", pending_count_o, 16);
    chk("cnt_full", full_o, 1);
    chk("cnt_not_empty", empty_o, 0);
    score_v_i = 1'b1;
    wb_yumi_i = 1'b1;
    req_v_i   = 3'b001;
    cyc();
    #1;
    chk("cnt_both", pending_count_o, 16);
    chk("cnt_both_full", full_o, 1);
    for (int c = 1; c <= 16; c++) begin
      score_v_i = 1'b0;
      wb_yumi_i = 1'b1;
      req_v_i   = (c < 16) ? 3'b001 : 3'b000;
      cyc();
    end
    wb_yumi_i = 1'b0;
    req_v_i   = '0;
    #1;
    chk("drain_cnt", pending_count_o, 0);
    chk("drain_empty", empty_o, 1);
    chk("drain_wb_v", wb_v_o, 0);

    // async reset mid-cycle with packet held and count 5
    for (int k = 0; k < 5; k++) begin
      score_v_i = 1'b1;
      req_v_i   = (k == 4) ? 3'b001 : 3'b000;
      cyc();
    end
    score_v_i = 1'b0;
    req_v_i   = '0;
    #1;
    chk("pre_rst_v", wb_v_o, 1);
    chk("pre_rst_cnt", pending_count_o, 5);
    #1;
    reset_i = 1'b1;
    #1;
    chk("arst_wb_v", wb_v_o, 0);
    chk("arst_cnt", pending_count_o, 0);
    chk("arst_empty", empty_o, 1);
    cyc();
    reset_i = 1'b0;
    cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
